// File: rtl/exec_operand_wb.sv
// exec_operand_wb: operand decode and write-back partner of the execute stage.
//   Decodes the 15-bit instruction word into OP_CODE / OP_DATA and the register
//   and RAM operands. It commits the execute stage's results into an 8x16
//   register file and a 256x16 data RAM one cycle after the operands were
//   sampled. Results still in flight are forwarded, so dependent instructions
//   issued back to back need no stall.
// Ports:
//   CLK_EX, RESET_N      clock; synchronous active-low reset
//   INSTR                instruction word at the current program counter
//   OP_CODE, OP_DATA     INSTR[14:11], INSTR[7:0]
//   REG_A, REG_B         operands for indices INSTR[10:8] / INSTR[7:5], bypassed
//   RAM_OUT              data RAM word at OP_DATA, bypassed
//   REG_IN, REG_WEN      register result and write request from execute
//   RAM_IN, RAM_WEN      store data and write request from execute
//   HALTED               sticky halt status
//   DBG_SEL, DBG_REG     raw register file read (no bypass)
module exec_operand_wb #(
  parameter int NREG      = 8,
  parameter int RAM_DEPTH = 256
) (
  input  logic        CLK_EX,
  input  logic        RESET_N,
  input  logic [14:0] INSTR,
  output logic [3:0]  OP_CODE,
  output logic [7:0]  OP_DATA,
  output logic [15:0] REG_A,
  output logic [15:0] REG_B,
  output logic [15:0] RAM_OUT,
  input  logic [15:0] REG_IN,
  input  logic        REG_WEN,
  input  logic [15:0] RAM_IN,
  input  logic        RAM_WEN,
  output logic        HALTED,
  input  logic [2:0]  DBG_SEL,
  output logic [15:0] DBG_REG
);

  localparam logic [3:0] OP_HLT = 4'hF;

  logic [15:0] rf  [NREG];
  logic [15:0] ram [RAM_DEPTH];

  logic [2:0]  wb_idx;
  logic [7:0]  st_addr;
  logic        wb_valid;
  logic        halted;

  logic [2:0]  idx_a;
  logic [2:0]  idx_b;
  logic        reg_commit;
  logic        ram_commit;

  assign OP_CODE = INSTR[14:11];
  assign OP_DATA = INSTR[7:0];
  assign idx_a   = INSTR[10:8];
  assign idx_b   = INSTR[7:5];
  assign HALTED  = halted;
  assign DBG_REG = rf[DBG_SEL];

  // wb_valid masks the execute stage's WEN outputs, which are not reset and
  // may hold stale requests across reset release.
  assign reg_commit = wb_valid && REG_WEN;
  assign ram_commit = wb_valid && RAM_WEN;

  always_comb begin
    REG_A   = rf[idx_a];
    REG_B   = rf[idx_b];
    RAM_OUT = ram[INSTR[7:0]];
    if (reg_commit && (wb_idx == idx_a)) REG_A = REG_IN;
    if (reg_commit && (wb_idx == idx_b)) REG_B = REG_IN;
    if (ram_commit && (st_addr == INSTR[7:0])) RAM_OUT = RAM_IN;
  end

  always_ff @(posedge CLK_EX) begin
    wb_idx   <= INSTR[10:8];
    st_addr  <= INSTR[7:0];
    wb_valid <= RESET_N;
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      halted <= 1'b0;
    end else begin
      if (reg_commit) rf[wb_idx] <= REG_IN;
      if (OP_CODE == OP_HLT) halted <= 1'b1;
    end
  end

  // Data RAM keeps its contents through reset; only the write is gated.
  always_ff @(posedge CLK_EX) begin
    if (RESET_N && ram_commit) ram[st_addr] <= RAM_IN;
  end

endmodule
